// File: rtl/ibex_alu_seq_pkg.sv
// ibex_alu_seq_pkg: operation/state encodings and op-class helpers for the sequential ALU
package ibex_alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_EQ   = 4'd8,
        OP_NE   = 4'd9,
        OP_LT   = 4'd10,
        OP_LTU  = 4'd11,
        OP_GE   = 4'd12,
        OP_GEU  = 4'd13,
        OP_ADDS = 4'd14,
        OP_SUBS = 4'd15
    } alu_seq_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_seq_state_e;

    function automatic logic is_shift_op(alu_seq_op_e op);
        return op inside {OP_SLL, OP_SRL, OP_SRA};
    endfunction

    function automatic logic is_cmp_op(alu_seq_op_e op);
        return op inside {OP_EQ, OP_NE, OP_LT, OP_LTU, OP_GE, OP_GEU};
    endfunction

endpackage

// File: rtl/ibex_alu_seq_shifter.sv
// ibex_alu_seq_shifter: combinational single-step shifter, up to SHIFT_STEP bits left/right/arithmetic
module ibex_alu_seq_shifter #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic [WIDTH-1:0]                  data_i,
    input  logic                              left_i,
    input  logic                              arith_i,
    input  logic [$clog2(SHIFT_STEP+1)-1:0]   amt_i,
    output logic [WIDTH-1:0]                  data_o
);

    // kept separate so the arithmetic shift stays in a signed context
    logic signed [WIDTH-1:0] sra;

    assign sra    = $signed(data_i) >>> amt_i;
    assign data_o = left_i ? data_i << amt_i : arith_i ? sra : data_i >> amt_i;

endmodule

// File: rtl/ibex_alu_seq.sv
// ibex_alu_seq: handshaked multi-cycle ALU with iterative shifts; ALU_SEQ_SAT_EN enables saturating ADDS/SUBS
module ibex_alu_seq
    import ibex_alu_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cmp_o,
    output logic             busy_o
);

    localparam int SW = $clog2(WIDTH);
    localparam int AW = $clog2(SHIFT_STEP + 1);

    alu_seq_state_e   state_q, state_d;
    alu_seq_op_e      op_q, op_d, op_in;
    logic [WIDTH-1:0] res_q, res_d, alu_res, sum, diff, adds, subs, shift_out;
    logic [SW-1:0]    rem_q, rem_d, shamt;
    logic [AW-1:0]    step;
    logic             cmp_q, cmp_d, cmp_in, accept, lt, ltu;

    assign op_in  = alu_seq_op_e'(op_i);
    assign shamt  = operand_b_i[SW-1:0];
    assign sum    = operand_a_i + operand_b_i;
    assign diff   = operand_a_i - operand_b_i;
    assign lt     = $signed(operand_a_i) < $signed(operand_b_i);
    assign ltu    = operand_a_i < operand_b_i;
    assign accept = in_valid_i & in_ready_o;

`ifdef ALU_SEQ_SAT_EN
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] sat_val;
    // overflow only when the wrapped sign disagrees with the operand sign
    assign add_ovf = (operand_a_i[WIDTH-1] == operand_b_i[WIDTH-1]) && (sum[WIDTH-1] != operand_a_i[WIDTH-1]);
    assign sub_ovf = (operand_a_i[WIDTH-1] != operand_b_i[WIDTH-1]) && (diff[WIDTH-1] != operand_a_i[WIDTH-1]);
    assign sat_val = operand_a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign adds    = add_ovf ? sat_val : sum;
    assign subs    = sub_ovf ? sat_val : diff;
`else
    assign adds = sum;
    assign subs = diff;
`endif

    // remaining shift is consumed in chunks of at most SHIFT_STEP
    assign step = (32'(rem_q) > SHIFT_STEP) ? AW'(SHIFT_STEP) : AW'(rem_q);

    ibex_alu_seq_shifter #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .data_i  (res_q),
        .left_i  (op_q == OP_SLL),
        .arith_i (op_q == OP_SRA),
        .amt_i   (step),
        .data_o  (shift_out)
    );

    // comparison outcome of the incoming operation (0 for non-compare ops)
    always_comb begin
        cmp_in = op_in == OP_EQ  ? operand_a_i == operand_b_i :
                 op_in == OP_NE  ? operand_a_i != operand_b_i :
                 op_in == OP_LT  ? lt  :
                 op_in == OP_LTU ? ltu :
                 op_in == OP_GE  ? !lt :
                 op_in == OP_GEU ? !ltu : 1'b0;
    end

    // first-cycle result; shift ops load operand A as the working value
    always_comb begin
        alu_res = {{(WIDTH-1){1'b0}}, cmp_in};
        case (op_in)
            OP_ADD:                 alu_res = sum;
            OP_SUB:                 alu_res = diff;
            OP_XOR:                 alu_res = operand_a_i ^ operand_b_i;
            OP_OR:                  alu_res = operand_a_i | operand_b_i;
            OP_AND:                 alu_res = operand_a_i & operand_b_i;
            OP_SLL, OP_SRL, OP_SRA: alu_res = operand_a_i;
            OP_ADDS:                alu_res = adds;
            OP_SUBS:                alu_res = subs;
            default:                ;
        endcase
    end

    // next-state: progress SHIFT/DONE, then let an accepted op override
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cmp_d   = cmp_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            S_SHIFT: begin
                res_d   = shift_out;
                rem_d   = rem_q - SW'(step);
                state_d = (rem_q == SW'(step)) ? S_DONE : S_SHIFT;
            end
            S_DONE:  state_d = out_ready_i ? S_IDLE : S_DONE;
            default: ;
        endcase
        if (accept) begin
            op_d    = op_in;
            res_d   = alu_res;
            cmp_d   = cmp_in;
            rem_d   = shamt;
            state_d = (is_shift_op(op_in) && shamt != '0) ? S_SHIFT : S_DONE;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            res_q   <= '0;
            cmp_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cmp_q   <= cmp_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready_i);
    assign out_valid_o = state_q == S_DONE;
    assign busy_o      = state_q != S_IDLE;
    assign result_o    = res_q;
    assign cmp_o       = cmp_q;

endmodule

// File: tb/tb_ibex_alu_seq.sv
// tb_ibex_alu_seq: directed bench with a transaction-level reference model for ibex_alu_seq (honours ALU_SEQ_SAT_EN)
module tb_ibex_alu_seq;
    import ibex_alu_seq_pkg::*;

    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, armed = 0;
    logic [3:0]  op_s = 0;
    logic [31:0] a_s = 0, b_s = 0;
    logic        in_ready, out_valid, cmp, busy;
    logic [31:0] result;
    int          nvec = 0, nerr = 0;

    ibex_alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op_s),
        .operand_a_i (a_s),
        .operand_b_i (b_s),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .cmp_o       (cmp),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic f_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd8:    return a == b;
            4'd9:    return a != b;
            4'd10:   return $signed(a) < $signed(b);
            4'd11:   return a < b;
            4'd12:   return $signed(a) >= $signed(b);
            4'd13:   return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_sat(input longint s);
`ifdef ALU_SEQ_SAT_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] f_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] s;
        longint sa, sb;
        int sh;
        sh = int'(b[4:0]);
        sa = $signed(a);
        sb = $signed(b);
        s  = $signed(a) >>> sh;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return s;
            4'd14:   return f_sat(sa + sb);
            4'd15:   return f_sat(sa - sb);
            default: return {31'd0, f_cmp(op, a, b)};
        endcase
    endfunction

    function automatic int f_lat(input logic [3:0] op, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        return (op inside {4'd5, 4'd6, 4'd7} && sh != 0) ? 1 + (sh + 3) / 4 : 1;
    endfunction

    // transaction model: an op becomes visible f_lat cycles after accept and stays until taken
    logic        m_pend = 0, m_valid = 0, m_cmp = 0, m_rdy;
    logic [31:0] m_res = 0;
    int          m_cnt = 0;
    assign m_rdy = !(m_pend || m_valid) || (m_valid && out_ready);

    always @(posedge clk) begin
        if (rst) begin
            m_pend  <= 0;
            m_valid <= 0;
        end else begin
            if (m_valid && out_ready) m_valid <= 0;
            if (m_pend) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_pend  <= 0;
                    m_valid <= 1;
                end
            end
            if (in_valid && m_rdy) begin
                m_res <= f_res(op_s, a_s, b_s);
                m_cmp <= f_cmp(op_s, a_s, b_s);
                if (f_lat(op_s, b_s) == 1) m_valid <= 1;
                else begin
                    m_pend <= 1;
                    m_cnt  <= f_lat(op_s, b_s) - 1;
                end
            end
        end
    end

    // cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (armed && !rst) begin
            chk("m_out_valid", out_valid, m_valid);
            chk("m_in_ready", in_ready, m_rdy);
            chk("m_busy", busy, m_pend || m_valid);
            if (m_valid) begin
                chk("m_result", result, m_res);
                chk("m_cmp", cmp, m_cmp);
            end
        end
    end

    task automatic run_op(input string n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input int el);
        int lat;
        @(negedge clk);
        in_valid = 1; op_s = op; a_s = a; b_s = b; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({n, "_lat"}, lat, el);
        chk({n, "_res"}, result, er);
        chk({n, "_cmp"}, cmp, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cmp", cmp, 0);
        rst = 0;
        armed = 1;

        run_op("add",   OP_ADD, 32'd10, 32'd5, 32'd15, 0, 1);
        run_op("sub",   OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 1);
        run_op("eq",    OP_EQ, 32'd100, 32'd100, 32'd1, 1, 1);
        run_op("lt",    OP_LT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1);
        run_op("ltu",   OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
        run_op("ge",    OP_GE, 32'd5, 32'hFFFF_FFFD, 32'd1, 1, 1);
        run_op("geu",   OP_GEU, 32'd5, 32'hFFFF_FFFD, 32'd0, 0, 1);
        run_op("ne",    OP_NE, 32'd1, 32'd2, 32'd1, 1, 1);
        run_op("xor",   OP_XOR, 32'hA5A5_0000, 32'h0F0F_FFFF, 32'hAAAA_FFFF, 0, 1);
        run_op("and",   OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 1);
        run_op("sra9",  OP_SRA, 32'h8000_0000, 32'd9, 32'hFFC0_0000, 0, 4);
        run_op("sll0",  OP_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 1);
        run_op("sll35", OP_SLL, 32'd1, 32'd35, 32'd8, 0, 2);
        run_op("srl31", OP_SRL, 32'hF000_0000, 32'd31, 32'd1, 0, 9);
        run_op("sra4",  OP_SRA, 32'h7000_0000, 32'd4, 32'h0700_0000, 0, 2);
`ifdef ALU_SEQ_SAT_EN
        run_op("adds",  OP_ADDS, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 0, 1);
        run_op("subs",  OP_SUBS, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 1);
`else
        run_op("adds",  OP_ADDS, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1);
        run_op("subs",  OP_SUBS, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1);
`endif
        run_op("adds_nov", OP_ADDS, 32'd7, 32'hFFFF_FFFE, 32'd5, 0, 1);

        // backpressure in DONE, then retire and accept in the same cycle
        @(negedge clk);
        in_valid = 1; op_s = OP_ADD; a_s = 32'd1; b_s = 32'd2; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (5) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, 32'd3);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1; in_valid = 1; op_s = OP_XOR; a_s = 32'hF0; b_s = 32'hFF;
        #1 chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", result, 32'h0F);

        // reset in the middle of a long shift
        @(negedge clk);
        in_valid = 1; op_s = OP_SRL; a_s = 32'hFFFF_FFFF; b_s = 32'd31;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("shift_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 0;
        repeat (12) begin
            @(negedge clk);
            chk("no_stale_valid", out_valid, 0);
        end

        // reset beats a simultaneous accept
        in_valid = 1; op_s = OP_ADD; a_s = 32'd4; b_s = 32'd4; rst = 1;
        @(negedge clk);
        in_valid = 0; rst = 0;
        @(negedge clk);
        chk("rst_vs_accept", out_valid, 0);

        run_op("post_rst", OP_OR, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 0, 1);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
